// File: rtl/rr_mux_n_if.sv
// rtl/rr_mux_n_if.sv - handshake bundle between CHANNELS producers, rr_mux_n and one consumer
//
// Purpose: carries the input streams, the merged output stream and its channel tag.
// Ports (signals):
//   in_valid  [CHANNELS]        producer i presents a word
//   in_data   [CHANNELS*WIDTH]  producer i word at [i*WIDTH +: WIDTH]
//   in_ready  [CHANNELS]        producer i word accepted this cycle
//   out_valid                   output register holds a word
//   out_data  [WIDTH]           registered selected word
//   out_chan  [SELW]            source channel of out_data
//   out_ready                   consumer accepts out_data this cycle
// Modports: slave = the selector, master = producers plus consumer.

interface rr_mux_n_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8
);
  localparam int SELW = $clog2(CHANNELS);

  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_ready;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic [SELW-1:0]           out_chan;
  logic                      out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan
  );
endinterface

// File: rtl/rr_mux_n.sv
// rtl/rr_mux_n.sv - N-channel registered selector with round-robin or fixed-priority arbitration
//
// Purpose: merges CHANNELS producer streams onto one registered output stream,
// tagging each word with its source channel.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  rr_mux_n_if.slave (in_valid/in_data/in_ready, out_valid/out_data/out_chan/out_ready)
// Parameters: WIDTH data bits, CHANNELS (power of two, >= 2),
//   MODE 0 = round-robin from ptr, MODE 1 = fixed priority (channel 0 highest).

module rr_mux_n #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8,
  parameter int MODE     = 0
) (
  input logic      clk,
  input logic      rst,
  rr_mux_n_if.slave bus
);
  localparam int SELW = $clog2(CHANNELS);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_chan_q,  out_chan_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;

  logic             grant_any;
  logic [SELW-1:0]  grant_idx;
  logic             can_load;
  logic             xfer;

  // Scan CHANNELS candidates; in round-robin the scan starts at ptr and the
  // SELW-bit add wraps modulo CHANNELS because CHANNELS is a power of two.
  always_comb begin
    logic [SELW-1:0] cand;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      cand = (MODE == 0) ? ptr_q + SELW'(k) : SELW'(k);
      if (!grant_any && bus.in_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign can_load = !out_valid_q || bus.out_ready;
  // Reset blocks acceptance so no producer sees a handshake that reset discards.
  assign xfer     = grant_any && can_load && !rst;

  assign bus.in_ready = xfer ? (CHANNELS'(1) << grant_idx) : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[grant_idx*WIDTH +: WIDTH];
      out_chan_d  = grant_idx;
      ptr_d       = grant_idx + SELW'(1);
    end else if (out_valid_q && bus.out_ready) begin
      // Drain only: the tag and data keep their last values.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
endmodule
